mod_exp_engine: RTL

Sequential left-to-right square-and-multiply modular exponentiation engine: computes result = base^exponent mod modulus. Drives the team's combinational divide_with_remainder divider with each raw product and consumes its remainder as the reduced value. Exponent bits are scanned with a fixed bit count, and the multiply step runs only on 1-bits. The resulting data-dependent timing and power profile is intentional, because this block is the side-channel attack target.

---
 rtl/mod_exp_pkg.sv | 22 ++
 rtl/divide_with_remainder.sv | 27 ++
 rtl/mod_exp_engine.sv | 114 +++++++++++
 3 files changed

// File: rtl/mod_exp_pkg.sv
// rtl/mod_exp_pkg.sv - shared types and constants for the modular exponentiation engine
package mod_exp_pkg;
   localparam int WIDTH_DEF = 32;

   function automatic int half_of(input int w);
      return w / 2;
   endfunction

   localparam int HALF     = half_of(WIDTH_DEF);
   localparam int BASE_LAT = 2 + 2 * HALF;

   typedef enum logic [2:0] {
      IDLE,
      BASE_RED,
      SQ_MUL,
      SQ_RED,
      M_MUL,
      M_RED,
      DONE,
      ERR
   } state_t;
endpackage

// File: rtl/divide_with_remainder.sv
// rtl/divide_with_remainder.sv - combinational restoring divider, quotient and remainder
module divide_with_remainder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   logic [WIDTH:0]   r;
   logic [WIDTH-1:0] q;

   // A zero divisor yields an all-ones quotient and returns the dividend as remainder.
   always_comb begin
      r = '0;
      q = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         r = {r[WIDTH-1:0], dividend[k]};
         if (r >= {1'b0, divisor}) begin
            r    = r - {1'b0, divisor};
            q[k] = 1'b1;
         end
      end
      quotient  = q;
      remainder = r[WIDTH-1:0];
   end
endmodule

// File: rtl/mod_exp_engine.sv
// rtl/mod_exp_engine.sv - left-to-right square-and-multiply modular exponentiation
module mod_exp_engine
   import mod_exp_pkg::*;
#(
   parameter int  WIDTH = WIDTH_DEF,
   localparam int HW    = half_of(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [HW-1:0] base,
   input  logic [HW-1:0] exponent,
   input  logic [HW-1:0] modulus,
   output logic [HW-1:0] result,
   output logic          done,
   output logic          busy,
   output logic          err
);
   localparam int IW = $clog2(HW);

   state_t           state, state_n;
   logic [WIDTH-1:0] prod;
   logic [WIDTH-1:0] quo, rem;
   logic [HW-1:0]    acc, b_r, exp_r, mod_r;
   logic [IW-1:0]    i;
   logic             last_bit;
   logic             unused_bits;

   divide_with_remainder #(.WIDTH(WIDTH)) u_div (
      .dividend  (prod),
      .divisor   ({{(WIDTH-HW){1'b0}}, mod_r}),
      .quotient  (quo),
      .remainder (rem)
   );

   assign unused_bits = ^{quo, rem[WIDTH-1:HW]};
   assign last_bit    = (i == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Multiply step only on 1-bits: timing deliberately follows the exponent.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (start) state_n = (modulus[HW-1:1] == '0) ? ERR : BASE_RED;
         BASE_RED: state_n = SQ_MUL;
         SQ_MUL:   state_n = SQ_RED;
         SQ_RED: begin
            if (exp_r[i])     state_n = M_MUL;
            else if (last_bit) state_n = DONE;
            else               state_n = SQ_MUL;
         end
         M_MUL:    state_n = M_RED;
         M_RED:    state_n = last_bit ? DONE : SQ_MUL;
         DONE:     state_n = IDLE;
         ERR:      state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod   <= '0;
         acc    <= '0;
         b_r    <= '0;
         exp_r  <= '0;
         mod_r  <= '0;
         i      <= '0;
         result <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         busy <= (state != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  exp_r <= exponent;
                  mod_r <= modulus;
                  prod  <= WIDTH'(base);
                  acc   <= HW'(1);
                  i     <= IW'(HW - 1);
                  err   <= 1'b0;
               end
            end
            BASE_RED: b_r  <= rem[HW-1:0];
            SQ_MUL:   prod <= WIDTH'(acc) * WIDTH'(acc);
            SQ_RED: begin
               acc <= rem[HW-1:0];
               if (!exp_r[i] && !last_bit) i <= i - 1'b1;
            end
            M_MUL:    prod <= WIDTH'(acc) * WIDTH'(b_r);
            M_RED: begin
               acc <= rem[HW-1:0];
               if (!last_bit) i <= i - 1'b1;
            end
            DONE: begin
               result <= acc;
               done   <= 1'b1;
            end
            ERR: begin
               result <= '0;
               err    <= 1'b1;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
